pdu_ddr_rd_arbiter: RTL and testbench
=====================================

// Module: pdu_ddr_rd_arbiter
// PURPOSE
//  Shares the single DDR read-request/response port between N_REQ requesters, e.g. the PDU data
//  mover's pdu_gen path and its CPU-metadata path. Issues requests under round-robin arbitration.
//  Records the owner of every issued request in an in-order owner FIFO. Steers each returning
//  512-bit response beat back to the requester that issued it. Sits between requesters and ddr_rd_* DRAM pins.
// PARAMETERS
//  N_REQ      2    number of requesters (2..4)
//  RD_W       $bits(ddr_rd_t)  read-request payload width
//  MAX_OUTST  64   max requests in flight (owner FIFO depth, power of 2)
// PORTS
//  clk                     in   1            single clock
//  rst                     in   1            asynchronous, active-high reset
//  req_data                in   N_REQ*RD_W   per-requester read request (ddr_rd_t)
//  req_valid               in   N_REQ        per-requester request valid
//  req_ready               out  N_REQ        per-requester accept (one-hot or zero)
//  resp_data               out  512          response beat, shared bus to all requesters
//  resp_valid              out  N_REQ        per-requester response valid (one-hot or zero)
//  resp_ready              in   N_REQ        per-requester response ready
//  ddr_rd_req_data         out  RD_W         request to DRAM
//  ddr_rd_req_valid        out  1            request valid to DRAM
//  ddr_rd_req_almost_full  in   1            DRAM request backpressure
//  ddr_rd_resp_data        in   512          response from DRAM (via response FIFO)
//  ddr_rd_resp_valid       in   1            response valid
//  ddr_rd_resp_ready       out  1            response pop
//  outstanding             out  $clog2(MAX_OUTST)+1  requests issued, response not yet delivered
//  err_orphan              out  1            sticky: a response arrived with no recorded owner
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0. The round-robin pointer is 0. The owner FIFO is empty.
//   - Reset mid-operation discards all in-flight ownership state.
//  Grant:
//   - can_issue = !ddr_rd_req_almost_full && outstanding < MAX_OUTST.
//   - When can_issue is true, grant goes to the first requester with req_valid set, scanning from
//     rr_ptr upward with wrap-around.
//   - req_ready[g] is asserted combinationally in the same cycle. Handshake is valid & ready.
//   - After a grant, rr_ptr = (g+1) mod N_REQ. With no grant, rr_ptr is held.
//  Issue:
//   - Issue is registered: ddr_rd_req_valid/data assert exactly 1 cycle after the grant cycle, for 1 cycle.
//   - Grant index g is pushed into the owner FIFO in the grant cycle.
//  Steer:
//   - h = owner FIFO head.
//   - resp_valid[h] = ddr_rd_resp_valid && !owner_empty. resp_data = ddr_rd_resp_data.
//   - ddr_rd_resp_ready = resp_ready[h].
//   - Pop the owner FIFO on ddr_rd_resp_valid && ddr_rd_resp_ready. Zero-cycle (combinational) steer path.
//   - The beat waits for requester h. Other requesters are never served out of order (head-of-line by design).
//  Outstanding counter:
//   - +1 on push, -1 on pop, unchanged on simultaneous push and pop.
//   - Never exceeds MAX_OUTST and never underflows.
//  Orphan response:
//   - If ddr_rd_resp_valid is set while the owner FIFO is empty: drive ddr_rd_resp_ready=1 and
//     resp_valid=0, which drops the beat, and set err_orphan.
//   - err_orphan is cleared only by rst.
//   - This includes beats returning after a reset mid-operation.
//  Full:
//   - At outstanding==MAX_OUTST, req_ready=0.
//   - A pop in that cycle does not allow a same-cycle grant; the grant happens in the next cycle.
//  Backpressure:
//   - ddr_rd_req_almost_full is sampled in the grant cycle.
//   - An already-registered request still issues. DRAM almost_full slack covers it.
// STRUCTURE
//  Shared package:
//   - ddr_rd_t.
//   - Requester-id localparams REQ_PDU_GEN=0 and REQ_CPU=1.
//   - MAX_OUTST default.
//  Sub-module rr_arbiter:
//   - Parameter N. Inputs req[N] and en. Outputs gnt one-hot and gnt_idx. Owns rr_ptr.
//  Owner FIFO:
//   - Inline register array of width $clog2(N_REQ).
//   - Pointers of width $clog2(MAX_OUTST)+1 so that full and empty are distinguishable.
// TESTING
//  1. Single requester: req0 valid with addr 0x100 -> ddr_rd_req_valid at t+1 with data 0x100;
//     resp beat 0xAA -> resp_valid=2'b01, outstanding returns to 0.
//  2. Both requesters valid for 6 cycles, rr_ptr=0 -> grants alternate 0,1,0,1,0,1;
//     3 responses to each, delivered in issue order.
//  3. Fill: MAX_OUTST=4 with no responses -> req_ready=0 on the 5th request and outstanding=4;
//     one response popped -> grant on the following cycle.
//  4. ddr_rd_req_almost_full=1 for 10 cycles with both valid -> no grants and ddr_rd_req_valid=0;
//     deassert -> grants resume at rr_ptr.
//  5. Head owner=1 with resp_ready[1]=0 for 5 cycles -> ddr_rd_resp_ready=0 and the beat is held
//     stable; ready -> a single pop.
//  6. Response beat with outstanding=0, including after an assertion of rst mid-burst -> beat dropped,
//     err_orphan=1 until the next rst.

Source files
------------

// File: rtl/pdu_ddr_rd_arbiter_pkg.sv
// Shared types and constants for the PDU DDR read-port arbiter.
//   ddr_rd_t      : read-request payload carried from a requester to DRAM
//   REQ_PDU_GEN   : requester index of the pdu_gen data path
//   REQ_CPU       : requester index of the CPU-metadata path
//   MAX_OUTST_DEF : default number of requests allowed in flight
package pdu_ddr_rd_arbiter_pkg;

    typedef struct packed {
        logic [7:0]  len;   // burst length in beats, minus one
        logic [39:0] addr;  // byte address
    } ddr_rd_t;

    localparam int REQ_PDU_GEN   = 0;
    localparam int REQ_CPU       = 1;
    localparam int MAX_OUTST_DEF = 64;
    localparam int RESP_W        = 512;

endpackage

// File: rtl/pdu_ddr_rd_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester request
//   en       : grant allowed this cycle
//   gnt      : one-hot grant (zero when nothing is granted)
//   gnt_idx  : binary index of the granted requester
// The scan starts at rr_ptr and wraps; after a grant the pointer moves to
// the requester just past the winner, otherwise it is held.
module pdu_ddr_rd_arbiter_rr_arbiter #(
    parameter int  N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          en,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] rr_ptr_q;
    logic [IW-1:0] rr_ptr_d;
    logic [IW-1:0] k;
    logic          found;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        k       = '0;
        for (int i = 0; i < N; i++) begin
            k = IW'((int'(rr_ptr_q) + i) % N);
            if (en && !found && req[k]) begin
                found   = 1'b1;
                gnt[k]  = 1'b1;
                gnt_idx = k;
            end
        end
        rr_ptr_d = rr_ptr_q;
        if (found) begin
            rr_ptr_d = (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: rtl/pdu_ddr_rd_arbiter.sv
// Shares one DDR read request/response port between N_REQ requesters.
//   req_data/req_valid/req_ready     : per-requester read requests (valid & ready)
//   resp_data/resp_valid/resp_ready  : response beats steered to the issuing requester
//   ddr_rd_req_*                     : registered request to DRAM, one cycle after grant
//   ddr_rd_resp_*                    : response beats from the DRAM response FIFO
//   outstanding                      : requests granted whose response is not yet delivered
//   err_orphan                       : sticky, a beat arrived with no recorded owner
// Handshakes: a transfer happens in a cycle where valid and ready are both 1.
// Owners are recorded in issue order; responses are returned strictly in that
// order, so a beat for a stalled requester blocks everyone behind it.
module pdu_ddr_rd_arbiter
    import pdu_ddr_rd_arbiter_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int RD_W      = $bits(ddr_rd_t),
    parameter int MAX_OUTST = MAX_OUTST_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ*RD_W-1:0]       req_data,
    input  logic [N_REQ-1:0]            req_valid,
    output logic [N_REQ-1:0]            req_ready,
    output logic [RESP_W-1:0]           resp_data,
    output logic [N_REQ-1:0]            resp_valid,
    input  logic [N_REQ-1:0]            resp_ready,
    output logic [RD_W-1:0]             ddr_rd_req_data,
    output logic                        ddr_rd_req_valid,
    input  logic                        ddr_rd_req_almost_full,
    input  logic [RESP_W-1:0]           ddr_rd_resp_data,
    input  logic                        ddr_rd_resp_valid,
    output logic                        ddr_rd_resp_ready,
    output logic [$clog2(MAX_OUTST):0]  outstanding,
    output logic                        err_orphan
);

    localparam int OW = $clog2(N_REQ);
    localparam int PW = $clog2(MAX_OUTST) + 1;
    localparam int AW = PW - 1;

    logic [RD_W-1:0] req_arr [N_REQ];
    logic [N_REQ-1:0] gnt;
    logic [OW-1:0]    gnt_idx;
    logic             can_issue;
    logic             push;
    logic             pop;
    logic             owner_empty;
    logic [OW-1:0]    head;

    logic [OW-1:0]    owner_q [MAX_OUTST];
    logic [OW-1:0]    owner_d [MAX_OUTST];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    outstanding_q, outstanding_d;
    logic             err_orphan_q, err_orphan_d;
    logic             issue_valid_q, issue_valid_d;
    logic [RD_W-1:0]  issue_data_q, issue_data_d;

    for (genvar r = 0; r < N_REQ; r++) begin : g_req_unpack
        assign req_arr[r] = req_data[r*RD_W +: RD_W];
    end

    // The count is the registered one, so a pop while full frees a slot
    // only from the next cycle on.
    assign can_issue = !ddr_rd_req_almost_full && (outstanding_q < PW'(MAX_OUTST));

    pdu_ddr_rd_arbiter_rr_arbiter #(.N(N_REQ)) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .en      (can_issue),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Steering: the head owner sees the beat; an ownerless beat is popped
    // and discarded so it cannot wedge the response FIFO.
    always_comb begin
        req_ready         = gnt;
        push              = |gnt;
        owner_empty       = (rd_ptr_q == wr_ptr_q);
        head              = owner_q[rd_ptr_q[AW-1:0]];
        resp_valid        = '0;
        ddr_rd_resp_ready = 1'b0;
        if (owner_empty) begin
            ddr_rd_resp_ready = ddr_rd_resp_valid;
        end else begin
            resp_valid[head]  = ddr_rd_resp_valid;
            ddr_rd_resp_ready = resp_ready[head];
        end
        pop = ddr_rd_resp_valid && ddr_rd_resp_ready && !owner_empty;
    end

    assign resp_data = ddr_rd_resp_data;

    always_comb begin
        owner_d = owner_q;
        if (push) begin
            owner_d[wr_ptr_q[AW-1:0]] = gnt_idx;
        end
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
        err_orphan_d  = err_orphan_q | (ddr_rd_resp_valid & owner_empty);
        issue_valid_d = push;
        issue_data_d  = push ? req_arr[gnt_idx] : issue_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTST; i++) begin
                owner_q[i] <= '0;
            end
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
            err_orphan_q  <= 1'b0;
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
        end else begin
            owner_q       <= owner_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            outstanding_q <= outstanding_d;
            err_orphan_q  <= err_orphan_d;
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
        end
    end

    assign ddr_rd_req_valid = issue_valid_q;
    assign ddr_rd_req_data  = issue_data_q;
    assign outstanding      = outstanding_q;
    assign err_orphan       = err_orphan_q;

endmodule

// File: tb/tb_pdu_ddr_rd_arbiter.sv
// Bench for pdu_ddr_rd_arbiter: table vectors, directed corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_pdu_ddr_rd_arbiter;
  import pdu_ddr_rd_arbiter_pkg::*;

  localparam int N    = 2;
  localparam int RW   = $bits(ddr_rd_t);
  localparam int MAXO = 4;

  logic              clk;
  logic              rst;
  logic [N*RW-1:0]   req_data;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [511:0]      resp_data;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready;
  logic [RW-1:0]     ddr_rd_req_data;
  logic              ddr_rd_req_valid;
  logic              af;
  logic [511:0]      dresp_data;
  logic              dresp_valid;
  logic              ddr_rd_resp_ready;
  logic [2:0]        outstanding;
  logic              err_orphan;

  pdu_ddr_rd_arbiter #(.N_REQ(N), .MAX_OUTST(MAXO)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .req_data               (req_data),
    .req_valid              (req_valid),
    .req_ready              (req_ready),
    .resp_data              (resp_data),
    .resp_valid             (resp_valid),
    .resp_ready             (resp_ready),
    .ddr_rd_req_data        (ddr_rd_req_data),
    .ddr_rd_req_valid       (ddr_rd_req_valid),
    .ddr_rd_req_almost_full (af),
    .ddr_rd_resp_data       (dresp_data),
    .ddr_rd_resp_valid      (dresp_valid),
    .ddr_rd_resp_ready      (ddr_rd_resp_ready),
    .outstanding            (outstanding),
    .err_orphan             (err_orphan)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec = 0;
  int n_err = 0;

  // reference model state: owners of in-flight requests in issue order
  int          m_own[$];
  int          m_rr;
  bit          m_err;
  bit          m_pend_v;
  logic [RW-1:0] m_pend_d;
  int          m_g;
  bit          m_pop;
  bit          m_orphan;
  logic [RW-1:0] m_nd;

  task automatic cmp(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  function automatic logic [N*RW-1:0] rand_req();
    logic [N*RW-1:0] v;
    for (int i = 0; i < N; i++) v[i*RW +: RW] = {$urandom_range(0, 255), $urandom(), $urandom_range(0, 255)};
    return v;
  endfunction

  // model evaluation at the sampling point, compares all outputs
  task automatic tick_chk();
    int g;
    int h;
    bit empty;
    logic [N-1:0] er;
    logic [N-1:0] ev;
    logic erdy;
    @(negedge clk);
    g = -1;
    if (!af && m_own.size() < MAXO) begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_rr + i) % N;
        if (g < 0 && req_valid[k]) g = k;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    empty = (m_own.size() == 0);
    h = empty ? 0 : m_own[0];
    ev = '0;
    if (!empty && dresp_valid) ev[h] = 1'b1;
    erdy = empty ? dresp_valid : resp_ready[h];
    cmp("req_ready", 512'(req_ready), 512'(er));
    cmp("resp_valid", 512'(resp_valid), 512'(ev));
    cmp("ddr_rd_resp_ready", 512'(ddr_rd_resp_ready), 512'(erdy));
    cmp("ddr_rd_req_valid", 512'(ddr_rd_req_valid), 512'(m_pend_v));
    if (m_pend_v) cmp("ddr_rd_req_data", 512'(ddr_rd_req_data), 512'(m_pend_d));
    if (ev != 0) cmp("resp_data", resp_data, dresp_data);
    cmp("outstanding", 512'(outstanding), 512'(m_own.size()));
    cmp("err_orphan", 512'(err_orphan), 512'(m_err));
    m_g      = g;
    m_pop    = dresp_valid && erdy && !empty;
    m_orphan = dresp_valid && empty;
    m_nd     = (g >= 0) ? req_data[g*RW +: RW] : '0;
  endtask

  task automatic tick_end();
    @(posedge clk);
    if (m_pop) void'(m_own.pop_front());
    if (m_g >= 0) begin
      m_own.push_back(m_g);
      m_rr = (m_g + 1) % N;
    end
    if (m_orphan) m_err = 1'b1;
    m_pend_v = (m_g >= 0);
    m_pend_d = m_nd;
    #1;
  endtask

  task automatic cycle();
    tick_chk();
    tick_end();
  endtask

  task automatic idle_inputs();
    req_valid   = '0;
    resp_ready  = '0;
    af          = 1'b0;
    dresp_valid = 1'b0;
    dresp_data  = '0;
    req_data    = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    m_own.delete();
    m_rr = 0; m_err = 1'b0; m_pend_v = 1'b0; m_pend_d = '0;
    @(negedge clk);
    cmp("rst_req_ready", 512'(req_ready), 512'(0));
    cmp("rst_resp_valid", 512'(resp_valid), 512'(0));
    cmp("rst_ddr_rd_req_valid", 512'(ddr_rd_req_valid), 512'(0));
    cmp("rst_ddr_rd_req_data", 512'(ddr_rd_req_data), 512'(0));
    cmp("rst_ddr_rd_resp_ready", 512'(ddr_rd_resp_ready), 512'(0));
    cmp("rst_outstanding", 512'(outstanding), 512'(0));
    cmp("rst_err_orphan", 512'(err_orphan), 512'(0));
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0] rv;
    logic       dv;
    logic [1:0] rr;
    logic [1:0] exp_rdy;
    logic [1:0] exp_rsp;
    logic       exp_iss;
    int         exp_out;
  } vec_t;

  vec_t tbl[9];
  logic [511:0] beat;

  initial begin
    rst = 1'b1;
    idle_inputs();
    // alternating grants with interleaved in-order responses
    tbl[0] = '{2'b11, 1'b0, 2'b11, 2'b01, 2'b00, 1'b0, 0};
    tbl[1] = '{2'b11, 1'b0, 2'b11, 2'b10, 2'b00, 1'b1, 1};
    tbl[2] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b01, 1'b1, 2};
    tbl[3] = '{2'b11, 1'b1, 2'b11, 2'b10, 2'b10, 1'b1, 2};
    tbl[4] = '{2'b11, 1'b1, 2'b11, 2'b01, 2'b01, 1'b1, 2};
    tbl[5] = '{2'b11, 1'b1, 2'b11, 2'b10, 2'b10, 1'b1, 2};
    tbl[6] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b01, 1'b1, 2};
    tbl[7] = '{2'b00, 1'b1, 2'b11, 2'b00, 2'b10, 1'b0, 1};
    tbl[8] = '{2'b00, 1'b0, 2'b11, 2'b00, 2'b00, 1'b0, 0};

    // single requester, first-issue latency
    do_reset();
    req_data  = '0;
    req_data[RW-1:0] = RW'(48'h100);
    req_valid = 2'b01;
    tick_chk();
    cmp("t1_grant", 512'(req_ready), 512'(2'b01));
    tick_end();
    req_valid = 2'b00;
    tick_chk();
    cmp("t1_issue_valid", 512'(ddr_rd_req_valid), 512'(1));
    cmp("t1_issue_data", 512'(ddr_rd_req_data), 512'(48'h100));
    tick_end();
    dresp_valid = 1'b1; dresp_data = 512'hAA; resp_ready = 2'b01;
    tick_chk();
    cmp("t1_resp_valid", 512'(resp_valid), 512'(2'b01));
    cmp("t1_resp_data", resp_data, 512'hAA);
    tick_end();
    dresp_valid = 1'b0;
    tick_chk();
    cmp("t1_outstanding", 512'(outstanding), 512'(0));
    tick_end();

    // table-driven alternation
    do_reset();
    for (int i = 0; i < 9; i++) begin
      req_valid = tbl[i].rv; dresp_valid = tbl[i].dv; resp_ready = tbl[i].rr;
      req_data = rand_req(); dresp_data = rand512();
      tick_chk();
      cmp("tbl_req_ready", 512'(req_ready), 512'(tbl[i].exp_rdy));
      cmp("tbl_resp_valid", 512'(resp_valid), 512'(tbl[i].exp_rsp));
      cmp("tbl_issue", 512'(ddr_rd_req_valid), 512'(tbl[i].exp_iss));
      cmp("tbl_outstanding", 512'(outstanding), 512'(tbl[i].exp_out));
      tick_end();
    end

    // fill to MAX_OUTST, pop while full grants only next cycle
    do_reset();
    req_valid = 2'b01;
    for (int i = 0; i < MAXO; i++) begin
      req_data = rand_req();
      cycle();
    end
    tick_chk();
    cmp("fill_ready", 512'(req_ready), 512'(0));
    cmp("fill_outstanding", 512'(outstanding), 512'(MAXO));
    tick_end();
    dresp_valid = 1'b1; resp_ready = 2'b01; dresp_data = rand512();
    tick_chk();
    cmp("fill_pop_no_grant", 512'(req_ready), 512'(0));
    tick_end();
    dresp_valid = 1'b0;
    tick_chk();
    cmp("fill_grant_after_pop", 512'(req_ready), 512'(2'b01));
    cmp("fill_outstanding_pop", 512'(outstanding), 512'(MAXO - 1));
    tick_end();
    req_valid = 2'b00; dresp_valid = 1'b1; resp_ready = 2'b11;
    for (int i = 0; i < MAXO; i++) cycle();
    dresp_valid = 1'b0;
    cycle();

    // almost_full blocks grants; resume at the held pointer
    do_reset();
    req_valid = 2'b01;
    cycle();
    req_valid = 2'b00; dresp_valid = 1'b1; resp_ready = 2'b11;
    cycle();
    dresp_valid = 1'b0;
    cycle();
    af = 1'b1; req_valid = 2'b11;
    for (int i = 0; i < 10; i++) begin
      tick_chk();
      cmp("af_no_grant", 512'(req_ready), 512'(0));
      cmp("af_no_issue", 512'(ddr_rd_req_valid), 512'(0));
      tick_end();
    end
    af = 1'b0;
    tick_chk();
    cmp("af_resume", 512'(req_ready), 512'(2'b10));
    tick_end();
    req_valid = 2'b00; dresp_valid = 1'b1;
    cycle();
    dresp_valid = 1'b0;
    cycle();

    // head-of-line hold for requester 1
    do_reset();
    req_valid = 2'b10; req_data = rand_req();
    cycle();
    req_valid = 2'b00; beat = rand512(); dresp_data = beat; dresp_valid = 1'b1; resp_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      tick_chk();
      cmp("hol_pop_ready", 512'(ddr_rd_resp_ready), 512'(0));
      cmp("hol_resp_valid", 512'(resp_valid), 512'(2'b10));
      cmp("hol_beat_stable", resp_data, beat);
      tick_end();
    end
    resp_ready = 2'b10;
    tick_chk();
    cmp("hol_release", 512'(ddr_rd_resp_ready), 512'(1));
    tick_end();
    dresp_valid = 1'b0;
    tick_chk();
    cmp("hol_single_pop", 512'(outstanding), 512'(0));
    tick_end();

    // orphan beats, also after a reset mid-burst
    do_reset();
    dresp_valid = 1'b1; dresp_data = rand512();
    tick_chk();
    cmp("orph_drop_ready", 512'(ddr_rd_resp_ready), 512'(1));
    cmp("orph_no_valid", 512'(resp_valid), 512'(0));
    tick_end();
    dresp_valid = 1'b0;
    tick_chk();
    cmp("orph_sticky", 512'(err_orphan), 512'(1));
    tick_end();
    do_reset();
    req_valid = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_data = rand_req();
      cycle();
    end
    do_reset();
    dresp_valid = 1'b1; resp_ready = 2'b11; dresp_data = rand512();
    tick_chk();
    cmp("orph_after_rst_ready", 512'(ddr_rd_resp_ready), 512'(1));
    cmp("orph_after_rst_valid", 512'(resp_valid), 512'(0));
    tick_end();
    dresp_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick_chk();
      cmp("orph_held", 512'(err_orphan), 512'(1));
      tick_end();
    end
    do_reset();

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req_valid   = 2'($urandom_range(0, 3));
      af          = ($urandom_range(0, 7) == 0);
      dresp_valid = 1'($urandom_range(0, 1));
      resp_ready  = 2'($urandom_range(0, 3));
      req_data    = rand_req();
      dresp_data  = rand512();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
